// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction fetch stage: word/field geometry,
// the default boot address and the fetch sequencer state encoding.
package cpu_pkg;

    localparam int INSTR_W    = 32;
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    function automatic logic [OPCODE_W-1:0] opcode_of(input logic [INSTR_W-1:0] word);
        return word[OPCODE_MSB:OPCODE_LSB];
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory request/response, decode handoff
// and the branch redirect from execute.
interface fetch_unit_if
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 32
);
    logic                imemReq;
    logic [ADDR_W-1:0]   imemAddr;
    logic                imemReady;
    logic                imemValid;
    logic [INSTR_W-1:0]  imemData;
    logic                instrValid;
    logic                instrReady;
    logic [INSTR_W-1:0]  instruction;
    logic [ADDR_W-1:0]   pcOut;
    logic [OPCODE_W-1:0] opcode;
    logic                branchTaken;
    logic [ADDR_W-1:0]   branchTarget;

    modport master (
        output imemReq, imemAddr, instrValid, instruction, pcOut, opcode,
        input  imemReady, imemValid, imemData, instrReady, branchTaken, branchTarget
    );

    modport slave (
        input  imemReq, imemAddr, instrValid, instruction, pcOut, opcode,
        output imemReady, imemValid, imemData, instrReady, branchTaken, branchTarget
    );
endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of {pc, instruction} pairs with a combinational head;
// flush has priority over a same-cycle push or pop.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 32,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  logic [ADDR_W-1:0]  push_pc,
    input  logic [INSTR_W-1:0] push_instr,
    output logic [ADDR_W-1:0]  head_pc,
    output logic [INSTR_W-1:0] head_instr,
    output logic [CNT_W-1:0]   count
);
    logic [ADDR_W-1:0]  pc_mem    [DEPTH];
    logic [INSTR_W-1:0] instr_mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]   count_reg;
    logic [DEPTH-1:0]   write_en;
    logic               do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign do_push = push && !flush && (count_reg != CNT_W'(DEPTH));
    assign do_pop  = pop && !flush && (count_reg != '0);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_we
            assign write_en[gi] = do_push && (wr_ptr_reg == PTR_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (write_en[i]) begin
                pc_mem[i]    <= push_pc;
                instr_mem[i] <= push_instr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            if (do_pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head_pc    = pc_mem[rd_ptr_reg];
    assign head_instr = instr_mem[rd_ptr_reg];
    assign count      = count_reg;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: credit-limited request issue, in-order response
// buffering, and redirect handling that drops stale in-flight words.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int               ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT),
    parameter int               DEPTH    = 2
) (
    input logic          clk,
    input logic          reset,
    fetch_unit_if.master bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_state_t       state_reg, state_next;
    logic [ADDR_W-1:0]  fetch_pc_reg, resp_pc_reg;
    logic [CNT_W-1:0]   outstanding_reg, outstanding_next;
    logic [CNT_W-1:0]   discard_reg, discard_next;
    logic [CNT_W-1:0]   fifo_count;
    logic [ADDR_W-1:0]  head_pc;
    logic [INSTR_W-1:0] head_instr;
    logic               credit_ok, accept, resp, push, pop, redirect;

    // Buffered plus in-flight words may never exceed the buffer size.
    assign credit_ok = ({1'b0, outstanding_reg} + {1'b0, fifo_count}) < (CNT_W + 1)'(DEPTH);
    assign accept    = bus.imemReq && bus.imemReady;
    assign resp      = bus.imemValid;
    assign redirect  = bus.branchTaken;
    assign push      = resp && (discard_reg == '0);
    assign pop       = bus.instrValid && bus.instrReady;

    always_comb begin
        state_next  = state_reg;
        bus.imemReq = 1'b0;
        case (state_reg)
            IDLE:  state_next = RUN;
            RUN: begin
                bus.imemReq = credit_ok;
                if (redirect && discard_next != '0) state_next = DRAIN;
            end
            DRAIN: begin
                bus.imemReq = credit_ok;
                if (discard_next == '0) state_next = RUN;
            end
            default: state_next = IDLE;
        endcase
    end

    // A redirect marks everything still in flight after this cycle as stale,
    // including a same-cycle accept but not a same-cycle response.
    always_comb begin
        outstanding_next = outstanding_reg;
        if (accept && !resp)      outstanding_next = outstanding_reg + CNT_W'(1);
        else if (!accept && resp) outstanding_next = outstanding_reg - CNT_W'(1);

        discard_next = discard_reg;
        if (redirect)                         discard_next = outstanding_next;
        else if (resp && discard_reg != '0)   discard_next = discard_reg - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            fetch_pc_reg    <= RESET_PC;
            resp_pc_reg     <= RESET_PC;
            outstanding_reg <= '0;
            discard_reg     <= '0;
        end else begin
            state_reg       <= state_next;
            outstanding_reg <= outstanding_next;
            discard_reg     <= discard_next;
            if (redirect)    fetch_pc_reg <= bus.branchTarget;
            else if (accept) fetch_pc_reg <= fetch_pc_reg + ADDR_W'(4);
            if (redirect)    resp_pc_reg  <= bus.branchTarget;
            else if (push)   resp_pc_reg  <= resp_pc_reg + ADDR_W'(4);
        end
    end

    fetch_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .pop        (pop),
        .flush      (redirect),
        .push_pc    (resp_pc_reg),
        .push_instr (bus.imemData),
        .head_pc    (head_pc),
        .head_instr (head_instr),
        .count      (fifo_count)
    );

    assign bus.imemAddr    = fetch_pc_reg;
    assign bus.instrValid  = (fifo_count != '0);
    assign bus.instruction = bus.instrValid ? head_instr : '0;
    assign bus.pcOut       = bus.instrValid ? head_pc : resp_pc_reg;
    assign bus.opcode      = opcode_of(bus.instruction);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory model with random latency plus a
// stream scoreboard that expects contiguous PCs restarting at each redirect.
module tb_fetch_unit;
    import cpu_pkg::*;

    localparam int DEPTH = 2;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fetch_unit_if #(.ADDR_W(32)) bus ();
    fetch_unit_if #(.ADDR_W(32)) bus2 ();

    fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    fetch_unit #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC), .DEPTH(DEPTH)) dut_wrap (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    mreq_t       mq[$];
    int          cyc = 0, checks = 0, errors = 0, delivered = 0;
    int          lat_min = 1, lat_max = 1;
    bit          rand_ready = 0, stall = 0;
    bit          prev_hold = 0, prev_branch = 0;
    logic [31:0] prev_addr = '0, exp_pc = '0, last_pc = '0, held_addr;
    logic [5:0]  last_op = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic tick();
        bit rsp;
        bus.imemReady = stall ? 1'b0 : (rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
        if (reset) begin
            mq.delete();
            bus.imemValid = 1'b0;
            exp_pc      = 32'h0;
            prev_hold   = 0;
            prev_branch = 0;
        end else begin
            if (bus.imemReq) check("credit_cap", mq.size() < DEPTH, 1'b1);
            if (bus.imemReq) check("addr_align", bus.imemAddr[1:0], 2'b00);
            if (prev_branch) check("flush_empty", bus.instrValid, 1'b0);
            if (prev_hold && !prev_branch) begin
                check("hold_req", bus.imemReq, 1'b1);
                check("hold_addr", bus.imemAddr, prev_addr);
            end
            rsp = (mq.size() != 0) && (mq[0].due <= cyc);
            bus.imemValid = rsp;
            bus.imemData  = rsp ? mq[0].addr : $urandom;
            if (rsp) void'(mq.pop_front());
            if (bus.instrValid && bus.instrReady) begin
                check("deliver_pc", bus.pcOut, exp_pc);
                check("deliver_instr", bus.instruction, exp_pc);
                check("deliver_opcode", bus.opcode, exp_pc[31:26]);
                last_pc = bus.pcOut;
                last_op = bus.opcode;
                exp_pc  = exp_pc + 32'd4;
                delivered++;
            end
            if (bus.branchTaken) exp_pc = bus.branchTarget;
            if (bus.imemReq && bus.imemReady)
                mq.push_back('{addr: bus.imemAddr, due: cyc + int'($urandom_range(lat_min, lat_max))});
            prev_hold   = bus.imemReq && !bus.imemReady;
            prev_addr   = bus.imemAddr;
            prev_branch = bus.branchTaken;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        bus.branchTaken = 1'b0;
        $display("cyc=%0d req=%0b addr=%08h valid=%0b pc=%08h instr=%08h delivered=%0d",
                 cyc, bus.imemReq, bus.imemAddr, bus.instrValid, bus.pcOut, bus.instruction, delivered);
    endtask

    task automatic run_until(input int target, input int budget, input string tag);
        int n = 0;
        while (delivered < target && n < budget) begin
            tick();
            n++;
        end
        check(tag, delivered >= target, 1'b1);
    endtask

    initial begin
        reset            = 1'b1;
        bus.imemReady    = 1'b1;
        bus.imemValid    = 1'b0;
        bus.imemData     = '0;
        bus.instrReady   = 1'b1;
        bus.branchTaken  = 1'b0;
        bus.branchTarget = '0;
        bus2.imemReady   = 1'b1;
        bus2.imemValid   = 1'b0;
        bus2.imemData    = '0;
        bus2.instrReady  = 1'b0;
        bus2.branchTaken = 1'b0;
        bus2.branchTarget = '0;

        @(negedge clk);
        tick();
        tick();
        check("rst_req", bus.imemReq, 1'b0);
        check("rst_valid", bus.instrValid, 1'b0);
        check("rst_instr", bus.instruction, 32'h0);
        check("rst_pcout", bus.pcOut, 32'h0);
        check("rst_opcode", bus.opcode, 6'h0);
        check("rst_addr", bus.imemAddr, 32'h0);
        check("rst_wrap_pcout", bus2.pcOut, 32'hFFFF_FFFC);

        reset = 1'b0;
        check("idle_req", bus.imemReq, 1'b0);
        check("idle_valid", bus.instrValid, 1'b0);
        check("idle_wrap_req", bus2.imemReq, 1'b0);
        tick();
        check("run_req", bus.imemReq, 1'b1);
        check("run_addr", bus.imemAddr, 32'h0);
        check("wrap_first_addr", bus2.imemAddr, 32'hFFFF_FFFC);
        tick();
        check("wrap_second_req", bus2.imemReq, 1'b1);
        check("wrap_second_addr", bus2.imemAddr, 32'h0000_0000);

        // Streaming with a one-cycle memory.
        run_until(3, 30, "stream_timeout");
        check("stream_last_pc", last_pc, 32'h8);
        check("wrap_credit_stop", bus2.imemReq, 1'b0);
        check("wrap_held_addr", bus2.imemAddr, 32'h4);

        // Opcode field taken from the top six bits.
        bus.branchTarget = 32'hFC00_0000;
        bus.branchTaken  = 1'b1;
        tick();
        run_until(delivered + 1, 30, "opcode_timeout");
        check("opcode_pc", last_pc, 32'hFC00_0000);
        check("opcode_3f", last_op, 6'h3F);

        // Decode backpressure fills the buffer and stops issue.
        bus.instrReady = 1'b0;
        repeat (12) tick();
        check("bp_valid", bus.instrValid, 1'b1);
        check("bp_req", bus.imemReq, 1'b0);
        held_addr = bus.imemAddr;
        repeat (3) tick();
        check("bp_addr_held", bus.imemAddr, held_addr);
        check("bp_req_still", bus.imemReq, 1'b0);
        bus.instrReady = 1'b1;
        run_until(delivered + 4, 40, "bp_resume_timeout");

        // Memory stall keeps the request and address frozen.
        for (int i = 0; i < 20 && !bus.imemReq; i++) tick();
        check("stall_pre_req", bus.imemReq, 1'b1);
        held_addr = bus.imemAddr;
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_req", bus.imemReq, 1'b1);
            check("stall_addr", bus.imemAddr, held_addr);
        end
        stall = 0;
        run_until(delivered + 2, 30, "stall_resume_timeout");

        // Redirect with two requests in flight.
        lat_min = 4;
        lat_max = 4;
        for (int i = 0; i < 30 && mq.size() != 2; i++) tick();
        check("redir_two_out", mq.size(), 2);
        bus.branchTarget = 32'h0000_0100;
        bus.branchTaken  = 1'b1;
        tick();
        check("redir_empty", bus.instrValid, 1'b0);
        run_until(delivered + 1, 40, "redir_timeout");
        check("redir_first_pc", last_pc, 32'h0000_0100);

        // Randomised traffic with redirects, including coincident ones.
        lat_min    = 1;
        lat_max    = 4;
        rand_ready = 1;
        for (int i = 0; i < 400; i++) begin
            bus.instrReady = ($urandom_range(0, 3) != 0);
            if (i == 200) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
                check("midrst_valid", bus.instrValid, 1'b0);
                check("midrst_addr", bus.imemAddr, 32'h0);
            end else if ($urandom_range(0, 15) == 0) begin
                bus.branchTarget = $urandom & 32'hFFFF_FFFC;
                bus.branchTaken  = 1'b1;
            end
            tick();
        end
        rand_ready     = 0;
        bus.instrReady = 1'b1;
        run_until(delivered + 4, 100, "final_timeout");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
